// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Bundle of the fetch stage's memory request/response bus,
//               redirect input and decode-side valid/ready handshake.
//               master = fetch stage, slave = memory/decode/execute side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DWIDTH = 32
);
  logic              redirect_fi;
  logic [DWIDTH-1:0] redirect_pc_fi;
  logic              imem_req_fo;
  logic [DWIDTH-1:0] imem_addr_fo;
  logic              imem_gnt_fi;
  logic              imem_rvalid_fi;
  logic [DWIDTH-1:0] imem_rdata_fi;
  logic              fetch_valid_fo;
  logic              fetch_ready_fi;
  logic [DWIDTH-1:0] pc_fo;
  logic [DWIDTH-1:0] pc_plus_fo;
  logic [DWIDTH-1:0] instruct_fo;

  modport master (
    input  redirect_fi, redirect_pc_fi, imem_gnt_fi, imem_rvalid_fi,
           imem_rdata_fi, fetch_ready_fi,
    output imem_req_fo, imem_addr_fo, fetch_valid_fo, pc_fo, pc_plus_fo,
           instruct_fo
  );

  modport slave (
    output redirect_fi, redirect_pc_fi, imem_gnt_fi, imem_rvalid_fi,
           imem_rdata_fi, fetch_ready_fi,
    input  imem_req_fo, imem_addr_fo, fetch_valid_fo, pc_fo, pc_plus_fo,
           instruct_fo
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Prefetching fetch stage. Issues word-aligned requests to
//               instruction memory under a credit limit, tracks in-flight
//               addresses, buffers responses in a DEPTH-entry queue and hands
//               them to decode. Redirects flush the queue and discard stale
//               in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int                DWIDTH          = 32,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [DWIDTH-1:0] RESET_PC        = '0
) (
  input  logic          Clk_Core,
  input  logic          Rst_Core,
  fetch_queue_if.master bus
);

  localparam int QAW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // fetch PC and in-flight bookkeeping
  logic [DWIDTH-1:0] fetch_pc;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     outstanding_next;
  logic [OW-1:0]     drop_cnt;

  // address-tracking FIFO: one entry per accepted, unreturned request
  logic [DWIDTH-1:0] trk_mem [MAX_OUTSTANDING];
  logic [TAW-1:0]    trk_wr;
  logic [TAW-1:0]    trk_rd;

  // instruction queue storage; the head entry drives decode directly
  logic [DWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] plus_mem [DEPTH];
  logic [DWIDTH-1:0] ins_mem  [DEPTH];
  logic [QAW-1:0]    q_wr;
  logic [QAW-1:0]    q_rd;
  logic [CNTW-1:0]   count;
  logic [CNTW-1:0]   count_next;

  logic credit;
  logic req;
  logic grant;
  logic resp;
  logic push;
  logic pop;
  logic valid;
  logic [DWIDTH-1:0] resp_addr;
  logic unused_pc_bits;

  function automatic logic [TAW-1:0] trk_inc(input logic [TAW-1:0] p);
    if (int'(p) == MAX_OUTSTANDING - 1) return '0;
    else return p + 1'b1;
  endfunction

  // Low two redirect bits are forced to zero, so they are intentionally unread.
  assign unused_pc_bits = ^bus.redirect_pc_fi[1:0];

  // Credit: never let queue entries plus in-flight requests exceed DEPTH,
  // so every response is guaranteed a free slot.
  assign credit = (int'(outstanding) < MAX_OUTSTANDING) &&
                  ((int'(count) + int'(outstanding)) < DEPTH);
  assign req    = !Rst_Core && !bus.redirect_fi && credit;
  assign grant  = req && bus.imem_gnt_fi;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp   = bus.imem_rvalid_fi && (outstanding != '0);
  assign push   = resp && (drop_cnt == '0) && !bus.redirect_fi;
  assign valid  = (count != '0) && !bus.redirect_fi;
  assign pop    = valid && bus.fetch_ready_fi;
  assign resp_addr = trk_mem[trk_rd];

  assign bus.imem_req_fo    = req;
  assign bus.imem_addr_fo   = fetch_pc;
  assign bus.fetch_valid_fo = valid;
  assign bus.pc_fo          = pc_mem[q_rd];
  assign bus.pc_plus_fo     = plus_mem[q_rd];
  assign bus.instruct_fo    = ins_mem[q_rd];

  // Next values of the in-flight and queue-occupancy counters.
  always_comb begin
    outstanding_next = outstanding;
    count_next       = count;
    case ({grant, resp})
      2'b10:   outstanding_next = outstanding + OW'(1);
      2'b01:   outstanding_next = outstanding - OW'(1);
      default: outstanding_next = outstanding;
    endcase
    case ({push, pop})
      2'b10:   count_next = count + CNTW'(1);
      2'b01:   count_next = count - CNTW'(1);
      default: count_next = count;
    endcase
  end

  // State update: reset, then redirect (flush) taking priority over normal flow.
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      trk_wr      <= '0;
      trk_rd      <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      count       <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) trk_mem[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        plus_mem[i] <= '0;
        ins_mem[i]  <= '0;
      end
    end else begin
      outstanding <= outstanding_next;
      // The tracking FIFO keeps running across redirects so stale responses
      // still retire their entries in order.
      if (grant) begin
        trk_mem[trk_wr] <= fetch_pc;
        trk_wr          <= trk_inc(trk_wr);
      end
      if (resp) trk_rd <= trk_inc(trk_rd);

      if (bus.redirect_fi) begin
        fetch_pc <= {bus.redirect_pc_fi[DWIDTH-1:2], 2'b00};
        // Everything still in flight after this cycle is stale.
        drop_cnt <= outstanding - OW'(resp);
        q_rd     <= q_wr;
        count    <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + DWIDTH'(4);
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
        if (push) begin
          pc_mem[q_wr]   <= resp_addr;
          plus_mem[q_wr] <= resp_addr + DWIDTH'(4);
          ins_mem[q_wr]  <= bus.imem_rdata_fi;
          q_wr           <= q_wr + 1'b1;
        end
        if (pop) q_rd <= q_rd + 1'b1;
        count <= count_next;
      end
    end
  end

endmodule
`default_nettype wire
